// File: rtl/wm_shift_scan_if.sv
// Byte-stream, SHIFT-table config and candidate/packet-status signals of the Wu-Manber shift-scan stage.
// Stream and candidate ports use valid/ready: a beat transfers on a rising clk edge where valid & ready are both high; the source holds its payload stable while valid is high and ready is low.
interface wm_shift_scan_if #(
  parameter int POS_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 in_sop;
  logic                 in_eop;
  logic                 cfg_we;
  logic [7:0]           cfg_addr;
  logic [2:0]           cfg_data;
  logic                 cand_valid;
  logic                 cand_ready;
  logic [POS_WIDTH-1:0] cand_pos;
  logic [7:0]           cand_hash;
  logic                 pkt_done;
  logic [POS_WIDTH-1:0] pkt_len;
  logic                 dbg_state;  // 0 = IDLE, 1 = SCAN

  modport master (
    output in_valid, in_data, in_sop, in_eop,
    output cfg_we, cfg_addr, cfg_data,
    output cand_ready,
    input  in_ready, cand_valid, cand_pos, cand_hash,
    input  pkt_done, pkt_len, dbg_state
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop,
    input  cfg_we, cfg_addr, cfg_data,
    input  cand_ready,
    output in_ready, cand_valid, cand_pos, cand_hash,
    output pkt_done, pkt_len, dbg_state
  );
endinterface

// File: rtl/wm_shift_scan.sv
// Wu-Manber shift-scan: hashes a sliding 2-byte block, skips by a programmable SHIFT table and
// emits zero-shift positions as candidates through a single-entry output buffer. M must be >= 2.
module wm_shift_scan #(
  parameter int M         = 4,
  parameter int POS_WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  wm_shift_scan_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam logic [POS_WIDTH-1:0] EVAL_IDX = POS_WIDTH'(M - 1);
  localparam logic [2:0]           SHIFT_RST = 3'd3;

  state_e               state_q, state_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [7:0]           prev_q, prev_d;
  logic [2:0]           skip_q, skip_d;
  logic                 cand_valid_q, cand_valid_d;
  logic [POS_WIDTH-1:0] cand_pos_q, cand_pos_d;
  logic [7:0]           cand_hash_q, cand_hash_d;
  logic                 pkt_done_q, pkt_done_d;
  logic [POS_WIDTH-1:0] pkt_len_q, pkt_len_d;
  logic [2:0]           table_q [256];

  logic                 in_ready_w;
  logic                 accept;
  logic                 start;
  logic                 cont;
  logic                 in_pkt;
  logic [POS_WIDTH-1:0] pos_inc;
  logic [POS_WIDTH-1:0] cur_idx;
  logic [POS_WIDTH-1:0] len_inc;
  logic [2:0]           cur_skip;
  logic [7:0]           hash_w;
  logic [2:0]           shift_w;
  logic                 eval_zone;
  logic                 lookup;
  logic                 load;

  // A held, unaccepted candidate freezes the whole scan pipeline.
  assign in_ready_w = !(cand_valid_q && !bus.cand_ready);
  assign accept     = bus.in_valid && in_ready_w;
  assign start      = accept && bus.in_sop;
  assign cont       = accept && !bus.in_sop && (state_q == ST_SCAN);
  assign in_pkt     = start || cont;

  // Byte index of the accepted byte; pos sticks at all-ones instead of wrapping.
  assign pos_inc  = (pos_q == '1) ? pos_q : pos_q + 1'b1;
  assign cur_idx  = start ? '0 : pos_inc;
  assign len_inc  = (cur_idx == '1) ? cur_idx : cur_idx + 1'b1;
  assign cur_skip = start ? 3'd0 : skip_q;

  // Table read uses the registered contents, so a same-cycle write is not visible yet.
  assign hash_w    = {prev_q[3:0], bus.in_data[3:0]};
  assign shift_w   = table_q[hash_w];
  assign eval_zone = in_pkt && (cur_idx >= EVAL_IDX);
  assign lookup    = eval_zone && (cur_skip == 3'd0);
  assign load      = lookup && (shift_w == 3'd0);

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    prev_d       = prev_q;
    skip_d       = skip_q;
    cand_valid_d = cand_valid_q && !bus.cand_ready;
    cand_pos_d   = cand_pos_q;
    cand_hash_d  = cand_hash_q;
    pkt_done_d   = 1'b0;
    pkt_len_d    = pkt_len_q;

    if (in_pkt) begin
      pos_d  = cur_idx;
      prev_d = bus.in_data;
      skip_d = cur_skip;
      if (lookup) begin
        skip_d = (shift_w == 3'd0) ? 3'd0 : shift_w - 3'd1;
      end else if (eval_zone) begin
        skip_d = cur_skip - 3'd1;
      end
      state_d = bus.in_eop ? ST_IDLE : ST_SCAN;
      if (bus.in_eop) begin
        pkt_done_d = 1'b1;
        pkt_len_d  = len_inc;
      end
    end

    if (load) begin
      cand_valid_d = 1'b1;
      cand_pos_d   = cur_idx;
      cand_hash_d  = hash_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pos_q        <= '0;
      prev_q       <= '0;
      skip_q       <= '0;
      cand_valid_q <= 1'b0;
      cand_pos_q   <= '0;
      cand_hash_q  <= '0;
      pkt_done_q   <= 1'b0;
      pkt_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      prev_q       <= prev_d;
      skip_q       <= skip_d;
      cand_valid_q <= cand_valid_d;
      cand_pos_q   <= cand_pos_d;
      cand_hash_q  <= cand_hash_d;
      pkt_done_q   <= pkt_done_d;
      pkt_len_q    <= pkt_len_d;
    end
  end

  // SHIFT table: configuration writes are honoured in every state, even while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        table_q[i] <= SHIFT_RST;
      end
    end else if (bus.cfg_we) begin
      table_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.cand_valid = cand_valid_q;
  assign bus.cand_pos   = cand_pos_q;
  assign bus.cand_hash  = cand_hash_q;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.pkt_len    = pkt_len_q;
  assign bus.dbg_state  = (state_q == ST_SCAN);

endmodule

// File: tb/tb_wm_shift_scan.sv
// Directed bench for wm_shift_scan: hand-computed candidates and packet lengths checked via scoreboards.
module tb_wm_shift_scan;
  localparam int PW = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [23:0]   exp_q[$];
  logic [PW-1:0] len_q[$];

  wm_shift_scan_if #(.POS_WIDTH(PW)) bus ();

  wm_shift_scan #(.M(4), .POS_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] addr, input logic [2:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    step(1);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // byte i of the n-byte burst is bytes[8*(n-1-i) +: 8], i.e. the first byte is the leftmost
  task automatic send_bytes(input logic [63:0] bytes, input int n, input bit sop_en, input bit eop_en);
    for (int i = 0; i < n; i++) begin
      bus.in_data  = bytes[8*(n-1-i) +: 8];
      bus.in_sop   = sop_en && (i == 0);
      bus.in_eop   = eop_en && (i == n - 1);
      bus.in_valid = 1'b1;
      wait_accept();
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cand_valid"}, 32'(bus.cand_valid), 32'd0);
    check({tag, "_cand_pos"},   32'(bus.cand_pos),   32'd0);
    check({tag, "_cand_hash"},  32'(bus.cand_hash),  32'd0);
    check({tag, "_pkt_done"},   32'(bus.pkt_done),   32'd0);
    check({tag, "_pkt_len"},    32'(bus.pkt_len),    32'd0);
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, "_state"},      32'(bus.dbg_state),  32'd0);
  endtask

  // scoreboard: every transferred candidate and every pkt_done pulse must be expected, in order
  always @(negedge clk) begin
    if (!rst && bus.cand_valid && bus.cand_ready) begin
      if (exp_q.size() == 0) check("cand_unexpected", {8'h0, bus.cand_pos, bus.cand_hash}, 32'hFFFF_FFFF);
      else                   check("cand", {8'h0, bus.cand_pos, bus.cand_hash}, {8'h0, exp_q.pop_front()});
    end
    if (!rst && bus.pkt_done) begin
      if (len_q.size() == 0) check("pkt_done_unexpected", 32'(bus.pkt_len), 32'hFFFF_FFFF);
      else                   check("pkt_len", 32'(bus.pkt_len), 32'(len_q.pop_front()));
    end
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = 8'h00;
    bus.cfg_data   = 3'd0;
    bus.cand_ready = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    check_reset_outputs("rst");

    // "xxABCDyy": 0x12 -> skip 1, pos 4 skipped, 0x34 at pos 5 is a hit
    cfg_write(8'h12, 3'd2);
    cfg_write(8'h23, 3'd1);
    cfg_write(8'h34, 3'd0);
    exp_q.push_back({16'd5, 8'h34});
    len_q.push_back(16'd8);
    send_bytes(64'h7878_4142_4344, 6, 1'b1, 1'b0);
    check("t1_latency_valid", 32'(bus.cand_valid), 32'd1);
    check("t1_latency_pos",   32'(bus.cand_pos),   32'd5);
    check("t1_latency_hash",  32'(bus.cand_hash),  32'h34);
    check("t1_state_scan",    32'(bus.dbg_state),  32'd1);
    send_bytes(64'h7979, 2, 1'b0, 1'b1);
    step(3);
    check("t1_len_held", 32'(bus.pkt_len), 32'd8);
    check("t1_state_idle", 32'(bus.dbg_state), 32'd0);

    // same stream, candidate held for 5 cycles
    bus.cand_ready = 1'b0;
    exp_q.push_back({16'd5, 8'h34});
    len_q.push_back(16'd8);
    fork
      send_bytes(64'h7878_4142_4344_7979, 8, 1'b1, 1'b1);
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
          @(negedge clk);
          if (bus.cand_valid) seen = 1'b1;
        end
        if (!seen) check("t2_cand_timeout", 32'd0, 32'd1);
        for (int c = 0; c < 5 && seen; c++) begin
          if (c > 0) @(negedge clk);
          check("t2_stall_in_ready", 32'(bus.in_ready),  32'd0);
          check("t2_stall_pos",      32'(bus.cand_pos),  32'd5);
          check("t2_stall_hash",     32'(bus.cand_hash), 32'h34);
        end
        @(posedge clk);
        #1;
        bus.cand_ready = 1'b1;
      end
    join
    step(3);

    // all-zero table: hits at every evaluated position
    for (int a = 0; a < 256; a++) cfg_write(8'(a), 3'd0);
    exp_q.push_back({16'd3, 8'h23});
    exp_q.push_back({16'd4, 8'h34});
    exp_q.push_back({16'd5, 8'h45});
    len_q.push_back(16'd6);
    send_bytes(64'h1011_1213_1415, 6, 1'b1, 1'b1);
    step(3);

    // reset mid-packet with a candidate pending
    bus.cand_ready = 1'b0;
    send_bytes(64'h1011_1213, 4, 1'b1, 1'b0);
    check("t5_pending", 32'(bus.cand_valid), 32'd1);
    rst = 1'b1;
    step(1);
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    bus.cand_ready = 1'b1;
    send_bytes(64'h2021_22, 3, 1'b0, 1'b0);
    check("t5_stray_idle", 32'(bus.dbg_state), 32'd0);
    // table back to 3: pos 3 lookup -> skip 2, nothing else evaluated
    len_q.push_back(16'd6);
    send_bytes(64'h1011_1213_1415, 6, 1'b1, 1'b1);
    step(3);

    // short packets
    len_q.push_back(16'd3);
    send_bytes(64'h0102_03, 3, 1'b1, 1'b1);
    len_q.push_back(16'd1);
    send_bytes(64'h55, 1, 1'b1, 1'b1);
    step(3);
    check("t4_len_held", 32'(bus.pkt_len), 32'd1);

    // write 0x34 <- 0 in the cycle of the CD lookup: old value 3 is used
    len_q.push_back(16'd6);
    send_bytes(64'h7878_43, 3, 1'b1, 1'b0);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 8'h34;
    bus.cfg_data = 3'd0;
    send_bytes(64'h44, 1, 1'b0, 1'b0);
    bus.cfg_we   = 1'b0;
    send_bytes(64'h7979, 2, 1'b0, 1'b1);
    step(3);
    exp_q.push_back({16'd3, 8'h34});
    len_q.push_back(16'd6);
    send_bytes(64'h7878_4344_7979, 6, 1'b1, 1'b1);
    step(4);

    check("cand_q_drained", 32'(exp_q.size()), 32'd0);
    check("len_q_drained",  32'(len_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wm_shift_scan.md
# wm_shift_scan

Wu-Manber shift-scan stage for the NIDS datapath. It consumes the packet byte stream and hashes a sliding 2-byte block at each evaluation point. A programmable SHIFT table decides how many bytes to skip; a zero shift emits a candidate match position. Candidates are presented on a valid/ready port whose payload the downstream `register` stage latches (`xload` = `cand_valid & cand_ready`).

## Interface
- `M`, 4: minimum pattern length; first evaluation at packet byte index `M-1`
- `POS_WIDTH`, 16: width of position/length counters
- Fixed, not parameters: block size B=2, hash width 8, shift width 3, table depth 256
- `clk` input 1: the single clock
- `reset` input 1: synchronous, active-high
- `in_valid` input 1: input byte valid
- `in_ready` output 1: block accepts byte this cycle
- `in_data` input 8: packet byte
- `in_sop` input 1: first byte of packet (qualified by accept)
- `in_eop` input 1: last byte of packet (qualified by accept)
- `cfg_we` input 1: SHIFT table write strobe
- `cfg_addr` input 8: SHIFT table address (hash)
- `cfg_data` input 3: shift value
- `cand_valid` output 1: candidate available
- `cand_ready` input 1: downstream accepts candidate
- `cand_pos` output POS_WIDTH: packet index of the block's last byte
- `cand_hash` output 8: hash that produced the zero shift
- `pkt_done` output 1: one-cycle pulse after the eop byte is accepted
- `pkt_len` output POS_WIDTH: byte count of the finished packet, valid with `pkt_done`, held afterwards

## Operation
- Accept = `in_valid & in_ready`; `in_ready = !(cand_valid & !cand_ready)`, so it is a single-entry output buffer.
- FSM states:
  - IDLE: non-sop bytes are accepted and discarded. An accept with `in_sop` starts a packet: pos=0, prev=byte, skip=0, go to SCAN.
  - SCAN: each accept advances pos by 1 and updates prev.
  - An accept with `in_eop` makes the next state IDLE; `pkt_done` pulses the next cycle with `pkt_len`=pos+1.
- A byte that has both sop and eop is a 1-byte packet.
- `in_sop` in SCAN restarts the packet; the partial packet produces no `pkt_done`.
- Evaluation on an accept at index pos ≥ M-1 with skip==0:
  - hash = {prev[3:0], in_data[3:0]}; s = table[hash].
  - If s==0: load candidate (pos, hash) and set skip=0.
  - Else: skip=s-1.
- If pos ≥ M-1 and skip≠0, skip decrements and there is no lookup. Below M-1 there is no lookup.
- Table:
  - 256×3 flops, all reset to 3 (M-B+1).
  - `cfg_we` writes in any state.
  - A lookup in the same cycle as a write to the same address reads the old value.
- pos saturates at all-ones and does not wrap; evaluation continues at the saturated index.
- A packet shorter than M bytes produces no candidates but still produces `pkt_done`.

## Timing
- Reset values:
  - `cand_valid`=0, `cand_pos`=0, `cand_hash`=0
  - `pkt_done`=0, `pkt_len`=0
  - `in_ready`=1
  - FSM=IDLE, skip=0, pos=0, table all 3
- Reset mid-packet drops the pending candidate and the packet; no `pkt_done`.
- Candidate latency: accept at cycle t gives `cand_valid`=1 at t+1.
- `cand_valid` holds, with payload stable, until `cand_ready` is sampled high.
- Same-cycle `cand_ready` and a new zero-shift accept: the new candidate replaces the old one at t+1, with no bubble.
- While `cand_valid & !cand_ready`: `in_ready`=0 and no state advances; `cfg_we` is still honored.
- `pkt_done` is independent of the candidate handshake. It may coincide with `cand_valid` for an eop-byte candidate.

## Test plan
- Table: 0x12←2, 0x23←1, 0x34←0; stream "xxABCDyy" (sop at byte 0, eop at byte 7), `cand_ready`=1 -> one candidate, `cand_pos`=5, `cand_hash`=0x34, one cycle after D is accepted. pos 4 is skipped (no lookup). `pkt_done` with `pkt_len`=8.
- Same stream with `cand_ready`=0 for 5 cycles after the candidate -> `in_ready`=0 and 'y' not consumed for 5 cycles. Payload stable. Resumes with no lost or duplicated bytes.
- Set all 256 entries to 0, send 6-byte packet -> candidates at pos 3, 4, 5 back-to-back with `cand_ready`=1; `pkt_len`=6.
- 3-byte packet with default table -> no candidate; `pkt_done` with `pkt_len`=3. A 1-byte sop+eop packet -> `pkt_len`=1.
- `reset` asserted mid-packet with a candidate pending -> next cycle `cand_valid`=0, all outputs at reset values, table reads 3. Bytes without sop are discarded until the next sop.
- `cfg_we` to 0x34 with data 0, in the same cycle as a "CD" lookup, with prior value 3 -> no candidate. A repeat packet afterwards -> candidate emitted.
